// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer for the 8-bit core.
// Drives per-cycle datapath strobes and counts retired instructions.
module multicycle_control #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       instr,
  input  logic             instr_valid,
  input  logic             mem_ready,
  output logic             fetch_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             alu_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_LW  = 2'b01,
    OP_SW  = 2'b10,
    OP_JMP = 2'b11
  } op_t;

  state_t           state_q;
  state_t           state_d;
  op_t              op_q;
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  // State, latched opcode and retire counter; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      op_q      <= OP_ADD;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (ir_write) op_q <= op_t'(instr[7:6]);
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Next state and strobes; a reset cycle suppresses every strobe
  // except fetch_req so an abandoned instruction has no side effects.
  always_comb begin
    state_d    = state_q;
    fetch_req  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        fetch_req = 1'b1;
        if (instr_valid) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op_q == OP_JMP) begin
          pc_write = 1'b1;
          pc_src   = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_src = (op_q == OP_LW) || (op_q == OP_SW);
        state_d = alu_src ? S_MEM : S_WB;
      end
      S_MEM: begin
        alu_src   = 1'b1;
        mem_read  = (op_q == OP_LW);
        mem_write = (op_q == OP_SW);
        if (mem_ready) begin
          state_d = mem_read ? S_WB : S_FETCH;
          retire  = !mem_read;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (op_q == OP_LW);
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    if (reset) begin
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      alu_src    = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      retire     = 1'b0;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control sequencer for the 8-bit microprocessor datapath. It fetches one 8-bit instruction at a time and decodes opcode `instr[7:6]`. It then steps the shared register file, ALU, sign-extender and data memory through FETCH/DECODE/EXEC/MEM/WB, driving one-hot-per-cycle control strobes. It sits between the instruction/data memory handshakes and the datapath muxes. It also counts retired instructions.

## Interface
Parameters:
- `CNT_W`, 8, width of retired-instruction counter.

Ports:
- `clk`  in  1  single system clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; sampled on rising edge of `clk`.
- `instr`  in  8  instruction word; `[7:6]` opcode, `[5:4]` rs, `[3:2]` rt, `[1:0]` imm/rd.
- `instr_valid`  in  1  instruction memory has `instr` valid this cycle.
- `mem_ready`  in  1  data memory completes the current read/write this cycle.
- `fetch_req`  out  1  request instruction at current PC.
- `ir_write`  out  1  latch `instr` into the IR.
- `pc_write`  out  1  update PC.
- `pc_src`  out  1  0 = PC+1, 1 = jump target (PC+signext(imm)).
- `alu_src`  out  1  0 = ALU B from rt, 1 = ALU B from the sign-extended `imm`.
- `mem_read`  out  1  data memory read strobe.
- `mem_write`  out  1  data memory write strobe.
- `mem_to_reg`  out  1  writeback from memory (1) or ALU (0).
- `reg_write`  out  1  register file write enable.
- `state`  out  3  current state encoding, for debug.
- `retired`  out  CNT_W  retired-instruction count.

## Operation
- Opcodes: 00 ADD (rd ← rs+rt), 01 LW (rt ← M[rs+sx(imm)]), 10 SW (M[rs+sx(imm)] ← rt), 11 JMP (PC ← PC+1+sx(imm)).
- The opcode is captured in an internal 2-bit register on the IR write. Decoding uses the latched copy, never the live `instr`.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Codes 5–7 are illegal and go to FETCH on the next edge with all strobes low.
- FETCH:
  - `fetch_req`=1.
  - If `instr_valid`=1, then `ir_write`=1, `pc_write`=1 and `pc_src`=0 (Mealy, same cycle), and the next state is DECODE.
  - Otherwise the block stays in FETCH.
- DECODE:
  - JMP: `pc_write`=1, `pc_src`=1, `retired`++, next state FETCH.
  - Any other opcode: next state EXEC.
- EXEC:
  - `alu_src`=1 for LW/SW, 0 for ADD.
  - ADD → WB; LW/SW → MEM.
- MEM:
  - LW: `mem_read`=1, `alu_src`=1. SW: `mem_write`=1, `alu_src`=1.
  - Strobes are held while `mem_ready`=0.
  - On `mem_ready`=1: LW → WB; SW → FETCH with `retired`++.
- WB:
  - `reg_write`=1; `mem_to_reg`=1 for LW, 0 for ADD.
  - `retired`++, next state FETCH.
- `retired` wraps from 2^CNT_W−1 to 0 and never saturates.
- Every strobe not listed for a state is 0.
- `mem_read` and `mem_write` are never both 1. `reg_write` is never 1 outside WB.

## Timing
- Reset: while `reset`=1 at an edge, the next state is FETCH, the latched opcode is 00 and `retired`=0. During the reset cycle all strobes except `fetch_req` are 0.
- A reset asserted mid-instruction abandons the instruction, with no retire and no `reg_write`/`mem_write` after that edge.
- Cycles from FETCH accept (with `instr_valid` high on the first FETCH cycle) to returning to FETCH:
  - JMP: 2.
  - ADD: 4.
  - SW: 4 plus memory wait cycles.
  - LW: 5 plus memory wait cycles.
- `instr_valid` is ignored outside FETCH. `mem_ready` is ignored outside MEM.
- `retired` updates on the edge leaving the final state and is visible the next cycle.

## Test plan
- Reset then ADD: assert `reset` for 2 cycles, present `instr`=8'b00_01_10_11 with `instr_valid` high → states 0,1,2,4,0. Strobes: `ir_write` in cycle 0, `reg_write`=1 and `mem_to_reg`=0 in cycle 3, `retired`=1.
- LW with 2 wait cycles: `instr`=8'b01_00_01_11, `mem_ready` low 2 cycles then high → `mem_read` high for 3 MEM cycles with `alu_src`=1, then WB with `mem_to_reg`=1. Total 7 cycles.
- SW with 0 waits: `instr`=8'b10_00_01_10, `mem_ready`=1 → `mem_write` high for exactly 1 cycle, no `reg_write`, back to FETCH after 4 cycles, `retired`++.
- JMP: `instr`=8'b11_00_00_10 → DECODE asserts `pc_write`=1 and `pc_src`=1. Back in FETCH on cycle 2.
- Fetch stall plus mid-op reset: hold `instr_valid`=0 for 5 cycles → stays in FETCH with `fetch_req`=1 and no `ir_write`. Then start an LW and assert `reset` in MEM → next state FETCH, `retired` unchanged at 0, no `reg_write`.
- Counter wrap: retire 256 ADDs from reset → `retired` reads 0 after the 256th and 1 after the 257th.
